// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type and timing constants for the fft frame sequencer
package fft_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_LOAD,
    ST_FLUSH,
    ST_START,
    ST_RUN
  } seq_state_e;

  // Extra cycles the watchdog tolerates beyond the nominal compute time.
  localparam int WD_MARGIN = 8;

  function automatic int fft_run_cycles(input int n_2);
    return n_2 * (1 << (n_2 - 1));
  endfunction

endpackage

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - feeds samples into fft, starts it, and streams its results back out
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int width = 16,
  parameter int N_2   = 5,
  localparam int IN_W = width - N_2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  input  logic [IN_W-1:0]    s_data,
  output logic               s_ready,
  output logic               fft_reset,
  output logic               fft_load,
  output logic [width-1:0]   fft_rd,
  output logic               fft_start,
  input  logic               fft_done,
  input  logic [2*width-1:0] fft_wd,
  output logic               res_valid,
  output logic [2*width-1:0] res_data,
  output logic [N_2-1:0]     res_idx,
  output logic               res_last,
  output logic               err_timeout
);

  localparam int WD_LIMIT = fft_run_cycles(N_2) + WD_MARGIN;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  localparam logic [N_2-1:0] LAST_IDX = {N_2{1'b1}};

  seq_state_e        state_q;
  logic [N_2-1:0]    smp_cnt_q;
  logic [N_2-1:0]    res_idx_q;
  logic [WD_W-1:0]   wd_cnt_q;
  logic              fft_load_q;
  logic [width-1:0]  fft_rd_q;
  logic              fft_start_q;
  logic              err_q;

  logic              accept;
  logic [width-1:0]  rd_d;

  assign accept = s_valid && (state_q == ST_LOAD);
  assign rd_d   = {{N_2{s_data[IN_W-1]}}, s_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RST;
      smp_cnt_q   <= '0;
      res_idx_q   <= '0;
      wd_cnt_q    <= '0;
      fft_load_q  <= 1'b0;
      fft_rd_q    <= '0;
      fft_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fft_load_q  <= 1'b0;
      fft_start_q <= 1'b0;
      unique case (state_q)
        ST_RST: begin
          smp_cnt_q <= '0;
          res_idx_q <= '0;
          wd_cnt_q  <= '0;
          state_q   <= ST_LOAD;
        end
        ST_LOAD: begin
          if (accept) begin
            fft_load_q <= 1'b1;
            fft_rd_q   <= rd_d;
            smp_cnt_q  <= smp_cnt_q + 1'b1;
            if (smp_cnt_q == LAST_IDX) begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          fft_start_q <= 1'b1;
          state_q     <= ST_START;
        end
        ST_START: begin
          wd_cnt_q <= '0;
          state_q  <= ST_RUN;
        end
        ST_RUN: begin
          // Results arrive one per done cycle; the watchdog only counts silent cycles.
          if (fft_done) begin
            wd_cnt_q  <= '0;
            res_idx_q <= res_idx_q + 1'b1;
            if (res_idx_q == LAST_IDX) begin
              state_q <= ST_RST;
            end
          end else if (wd_cnt_q == WD_W'(WD_LIMIT - 1)) begin
            err_q   <= 1'b1;
            state_q <= ST_RST;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_RST;
      endcase
    end
  end

  assign s_ready     = (state_q == ST_LOAD);
  assign fft_reset   = (state_q == ST_RST);
  assign fft_load    = fft_load_q;
  assign fft_rd      = fft_rd_q;
  assign fft_start   = fft_start_q;
  assign res_valid   = (state_q == ST_RUN) && fft_done;
  assign res_data    = fft_wd;
  assign res_idx     = res_idx_q;
  assign res_last    = res_valid && (res_idx_q == LAST_IDX);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - directed, table-driven bench for fft_frame_sequencer
module tb_fft_frame_sequencer;

  localparam int W    = 16;
  localparam int N2   = 5;
  localparam int IN_W = W - N2;
  localparam int N    = 32;

  typedef struct {
    logic [IN_W-1:0] din;
    logic [W-1:0]    exp_rd;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              s_valid = 1'b0;
  logic [IN_W-1:0]   s_data = '0;
  logic              s_ready;
  logic              fft_reset;
  logic              fft_load;
  logic [W-1:0]      fft_rd;
  logic              fft_start;
  logic              fft_done = 1'b0;
  logic [2*W-1:0]    fft_wd = '0;
  logic              res_valid;
  logic [2*W-1:0]    res_data;
  logic [N2-1:0]     res_idx;
  logic              res_last;
  logic              err_timeout;

  fft_frame_sequencer #(.width(W), .N_2(N2)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fft_reset(fft_reset), .fft_load(fft_load), .fft_rd(fft_rd), .fft_start(fft_start),
    .fft_done(fft_done), .fft_wd(fft_wd), .res_valid(res_valid), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0, last_acc = 0, start_cyc = 0;
  int acc_cnt = 0, load_cnt = 0, start_cnt = 0;
  logic [W-1:0] load_q[$];
  logic [W-1:0] exp_rd[N];
  vec_t vecs[8];

  always @(posedge clk) begin
    if (reset && s_valid && s_ready) begin
      acc_cnt++;
      last_acc = cyc;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (fft_load) begin
        load_cnt++;
        load_q.push_back(fft_rd);
      end
      if (fft_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_frame();
    acc_cnt = 0;
    load_cnt = 0;
    start_cnt = 0;
    load_q.delete();
  endtask

  task automatic send(input logic [IN_W-1:0] d, input int gap);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!s_ready) fail("send_ready");
    tick();
    s_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_start();
    int guard = 0;
    while (!fft_start && guard < 200) begin
      tick();
      guard++;
    end
    if (!fft_start) fail("start_wait");
  endtask

  task automatic check_frame();
    check("load_count", 32'(load_cnt), 32'd32);
    check("accept_count", 32'(acc_cnt), 32'd32);
    check("start_count", 32'(start_cnt), 32'd1);
    check("start_after_last_accept", 32'(start_cyc - last_acc), 32'd2);
    for (int i = 0; i < load_q.size() && i < N; i++)
      check($sformatf("fft_rd[%0d]", i), 32'(load_q[i]), 32'(exp_rd[i]));
  endtask

  task automatic drain_results();
    repeat (80) tick();
    for (int k = 0; k < N; k++) begin
      fft_done = 1'b1;
      fft_wd   = 32'(k);
      #1;
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_idx", 32'(res_idx), 32'(k));
      check("res_data", res_data, 32'(k));
      check("res_last", 32'(res_last), (k == N - 1) ? 32'd1 : 32'd0);
      tick();
    end
    fft_done = 1'b0;
    fft_wd   = '0;
    #1;
    check("post_frame_fft_reset", 32'(fft_reset), 32'd1);
    check("post_frame_s_ready", 32'(s_ready), 32'd0);
    check("post_frame_res_valid", 32'(res_valid), 32'd0);
    tick();
    check("next_frame_s_ready", 32'(s_ready), 32'd1);
    check("next_frame_fft_reset", 32'(fft_reset), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fft_reset"}, 32'(fft_reset), 32'd1);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_fft_load"}, 32'(fft_load), 32'd0);
    check({tag, "_fft_rd"}, 32'(fft_rd), 32'd0);
    check({tag, "_fft_start"}, 32'(fft_start), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_idx"}, 32'(res_idx), 32'd0);
    check({tag, "_res_last"}, 32'(res_last), 32'd0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{11'h001, 16'h0001};
    vecs[1] = '{11'h400, 16'hFC00};
    vecs[2] = '{11'h3FF, 16'h03FF};
    vecs[3] = '{11'h7FF, 16'hFFFF};
    vecs[4] = '{11'h000, 16'h0000};
    vecs[5] = '{11'h555, 16'hFD55};
    vecs[6] = '{11'h2AA, 16'h02AA};
    vecs[7] = '{11'h401, 16'hFC01};

    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    #1;
    check("rst_cycle_s_ready", 32'(s_ready), 32'd0);
    check("rst_cycle_fft_reset", 32'(fft_reset), 32'd1);
    tick();
    check("first_load_s_ready", 32'(s_ready), 32'd1);

    // back-to-back unit samples
    begin_frame();
    for (int i = 0; i < N; i++) exp_rd[i] = 16'h0001;
    for (int i = 0; i < N; i++) send(11'h001, 0);
    wait_start();
    check_frame();
    drain_results();

    // sign-extension table with s_valid toggling every other cycle
    begin_frame();
    for (int i = 0; i < N; i++) exp_rd[i] = vecs[i % 8].exp_rd;
    for (int i = 0; i < N - 1; i++) send(vecs[i % 8].din, 1);
    repeat (3) tick();
    check("no_start_before_last", 32'(start_cnt), 32'd0);
    check("still_loading", 32'(s_ready), 32'd1);
    check("loads_before_last", 32'(load_cnt), 32'd31);
    send(vecs[(N - 1) % 8].din, 1);
    wait_start();
    check_frame();
    drain_results();

    // most-negative samples, fft never finishes
    begin_frame();
    for (int i = 0; i < N; i++) exp_rd[i] = 16'hFC00;
    for (int i = 0; i < N; i++) send(11'h400, 0);
    wait_start();
    check_frame();
    @(posedge clk);
    n = 0;
    while (!err_timeout && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("watchdog_cycles", 32'(n), 32'd88);
    check("watchdog_fft_reset", 32'(fft_reset), 32'd1);
    check("watchdog_s_ready", 32'(s_ready), 32'd0);
    tick();

    // recovery frame after timeout
    begin_frame();
    for (int i = 0; i < N; i++) exp_rd[i] = 16'hFFFF;
    for (int i = 0; i < N; i++) send(11'h7FF, 0);
    wait_start();
    check_frame();
    drain_results();
    check("err_sticky", 32'(err_timeout), 32'd1);

    // asynchronous reset mid-frame
    begin_frame();
    for (int i = 0; i < 10; i++) send(11'h123, 0);
    check("pre_reset_load", 32'(fft_load), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    reset = 1'b1;
    #1;
    tick();
    begin_frame();
    for (int i = 0; i < N; i++) exp_rd[i] = 16'h0123;
    for (int i = 0; i < N - 1; i++) send(11'h123, 0);
    repeat (3) tick();
    check("midreset_no_early_start", 32'(start_cnt), 32'd0);
    send(11'h123, 0);
    wait_start();
    check_frame();
    drain_results();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Front-end controller directly upstream of `fft`.
- Accepts a ready/valid stream of signed real samples and sign-extends each to `width` bits.
- Drives the `fft` control inputs: `reset` pulse, `load` strobes, `start` pulse.
- Waits for `done`, then forwards the 2^N_2 complex results with a bin index and a last flag.
- One instance per `fft` instance; the two share a clock.

## Interface
- `width`, 16: complex half-width of the `fft` datapath.
- `N_2`, 5: log2 of the FFT point count; N = 2^N_2.
- `IN_W`, localparam = width-N_2: input sample width, leaving headroom for bit growth.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  upstream sample valid.
- `s_data`  in  IN_W  signed real sample.
- `s_ready`  out  1  sequencer accepts a sample this cycle.
- `fft_reset`  out  1  to `fft` reset (active-high, synchronous on the `fft` side).
- `fft_load`  out  1  to `fft` load.
- `fft_rd`  out  width  to `fft` rd, sign-extended sample.
- `fft_start`  out  1  to `fft` start.
- `fft_done`  in  1  from `fft` done.
- `fft_wd`  in  2*width  from `fft` wd, complex result {re,im}.
- `res_valid`  out  1  `res_data` holds bin `res_idx`.
- `res_data`  out  2*width  equals `fft_wd`, combinational pass-through.
- `res_idx`  out  N_2  frequency bin, natural order.
- `res_last`  out  1  high with the valid for bin N-1.
- `err_timeout`  out  1  sticky; set by the watchdog.

## Operation
- FSM states: RST, LOAD, FLUSH, START, RUN.
- RST: `fft_reset`=1 for exactly one cycle; clears the sample counter and `res_idx`. Next state: LOAD.
- LOAD:
  - `s_ready`=1.
  - An accept (`s_valid & s_ready`) registers `fft_rd` = sign-extended `s_data` and sets `fft_load`=1 in the following cycle. `fft_load`=0 in every other cycle.
  - The sample counter increments on each accept.
  - Gaps in `s_valid` are legal; `fft` only advances on load cycles.
  - The Nth accept moves the FSM to FLUSH.
- FLUSH: one cycle; the last `fft_load` strobe is active here. Next state: START.
- START: `fft_start`=1 for one cycle. Next state: RUN.
- RUN:
  - Waits for `fft_done`.
  - Every cycle with `fft_done`=1: `res_valid`=1, `res_idx` increments after that cycle.
  - The cycle with `res_idx`=N-1 and `res_valid` asserts `res_last` and returns the FSM to RST. This resets `fft` and begins the next frame.
- There is no result backpressure: `fft` cannot stall, so the consumer must take one result per cycle.
- Watchdog: a cycle counter in RUN.
  - Limit = N_2·2^(N_2-1) + 8 cycles without `fft_done`.
  - On reaching the limit: set `err_timeout` and go to RST; the partially loaded/processed frame is discarded.
  - `err_timeout` clears only on `reset`.
- Sign extension: `fft_rd` = {{N_2{s_data[IN_W-1]}}, s_data}.

## Timing
- Reset values while `reset`=0: state RST, `s_ready`=0, `fft_load`=0, `fft_rd`=0, `fft_start`=0, `res_valid`=0, `res_idx`=0, `res_last`=0, `err_timeout`=0.
- `fft_reset` is 1 in RST, including during reset assertion.
- After `reset` deasserts: one RST cycle, then `s_ready`=1.
- `fft_load` and `fft_rd` are registered: 1-cycle latency from accept.
- Minimum frame period: 1 (RST) + N (LOAD) + 1 (FLUSH) + 1 (START) + N_2·2^(N_2-1) (compute) + N (drain) cycles.
- Async reset mid-frame: all state clears immediately. The `fft` is re-reset by RST and the partial frame is lost.
- `s_valid` while `s_ready`=0: ignored; the upstream must hold the sample.

## Structure
- Package `fft_pkg`:
  - FSM state enum typedef.
  - Function `fft_run_cycles(N_2)` returning N_2·2^(N_2-1).
  - Localparam for the watchdog margin (8).
- Single module; FSM, sample counter, result counter and watchdog counter inline. No sub-module is warranted.

## Test plan
- Reset then N=32 back-to-back samples of 0x001 → exactly 32 `fft_load` pulses, each with `fft_rd`=0x0001. `fft_start` occurs 2 cycles after the last accept.
- `s_data`=0x400 (most negative, IN_W=11) → `fft_rd`=0xFC00.
- `s_valid` toggled every other cycle → still exactly 32 loads, and FLUSH/START occur only after the 32nd accept.
- Model asserts `fft_done` 80 cycles after start and drives `fft_wd`=k on its kth done cycle → `res_idx`/`res_data` 0..31 in consecutive cycles. `res_last` only at 31, then `fft_reset` pulses and `s_ready` rises 1 cycle later.
- `fft_done` never asserted → `err_timeout`=1 exactly 88 cycles after entering RUN, FSM back in RST, next frame loads normally.
- `reset` pulled low after 10 accepts → all outputs return to their reset values immediately. After release, 32 fresh accepts are required before `fft_start`.
